smpc_pad_scanner: RTL and testbench
===================================

Name: smpc_pad_scanner

Overview:
- Peripheral byte sequencer feeding the SMPC OREG datapath during the INTBACK peripheral phase.
- Responds to INPUT_ACT by writing one peripheral-data byte per INPUT_WE pulse, paced to emulate SMPC serial port timing.
- Formats two Saturn digital-pad ports, each either connected or disconnected, into standard port/ID/data bytes.
- Byte selection is indexed by the SMPC's own INPUT_POS, so output stays aligned with the OREG write pointer.

Parameters:
FIRST_DELAY, 16'd400, CE cycles from INPUT_ACT rise to first INPUT_WE
BYTE_GAP, 16'd20, CE cycles between consecutive INPUT_WE pulses

Ports:
CLK  in  1  system clock, the only clock
RST_N  in  1  reset, synchronous, active-low
CE  in  1  clock enable; all state advances only when CE=1
PORT_EN  in  2  [0]=pad on port 1 connected, [1]=pad on port 2 connected
JOY1  in  16  port 1 buttons, active-high; [15:3]={Right,Left,Down,Up,Start,A,C,B,R,X,Y,Z,L}, [2:0] ignored
JOY2  in  16  port 2 buttons, same layout
INPUT_ACT  in  1  SMPC request; high while SMPC accepts peripheral bytes
INPUT_POS  in  5  SMPC OREG write index of next byte
INPUT_DATA  out  8  byte to write, valid with INPUT_WE
INPUT_WE  out  1  write strobe, high for exactly one CE-active cycle
BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset (RST_N=0 at CLK edge): state=IDLE, INPUT_DATA=8'h00, INPUT_WE=0, BUSY=0, gap counter=0, snapshots=0, ACT_D=0.
- ACT_D is INPUT_ACT registered on CE cycles, used for rise detection.
- Outputs are registered and change only on CE cycles, so INPUT_WE high spans exactly one CE-active cycle.
- States:
  - IDLE: on INPUT_ACT=1 and ACT_D=0:
    - latch PORT_EN to C, JOY1 to S1, JOY2 to S2;
    - set CNT=FIRST_DELAY;
    - go GAP.
  - GAP: if CNT!=0, CNT-=1. If CNT==0, go WRITE; FIRST_DELAY/BYTE_GAP=0 gives WRITE on the next CE cycle.
  - WRITE, one CE cycle:
    - INPUT_WE=1;
    - INPUT_DATA=BYTE(INPUT_POS);
    - if INPUT_POS==30, go DONE;
    - else CNT=BYTE_GAP, go GAP.
    - INPUT_WE returns to 0 on the following CE cycle.
  - DONE: INPUT_WE=0; wait for INPUT_ACT=0, then go IDLE.
- Abort:
  - INPUT_ACT=0 in GAP or WRITE: go IDLE on that CE cycle, INPUT_WE=0, no write.
  - Takes priority over WRITE.
- Re-arm: new INPUT_ACT rise is honoured only from IDLE, i.e. after ACT_D has been 0 for at least one CE cycle.
- Byte map, with L1 = C[0]?4:1 and L2 = C[1]?4:1:
  - pos < L1: port-1 block;
  - L1 <= pos < L1+L2: port-2 block at offset pos-L1;
  - otherwise 8'h00 filler up to pos 30.
- Port block:
  - connected: F1 (direct, 1 device), 02 (digital pad, 2 data bytes), ~S[15:8], {~S[7:3],3'b100};
  - disconnected: single byte F0.
- INPUT_POS out of expected order is not corrected; the byte is always derived from the current INPUT_POS value.
- Snapshots are held for the whole session; JOY changes mid-session do not affect output.
- CE=0: all state, counters and outputs hold.
- RST_N asserted mid-session: immediate return to reset values regardless of INPUT_ACT.

Test Plan:
- Reset with RST_N=0 for 2 cycles, CE=1 -> INPUT_WE=0, INPUT_DATA=00, BUSY=0.
- PORT_EN=11, JOY1=16'h8000 (Right), JOY2=16'h0008 (L), FIRST_DELAY=400, BYTE_GAP=20, bench SMPC increments POS per WE -> bytes F1,02,7F,FC,F1,02,FF,F4, then 23×00; first WE 401 CE cycles after rise; 21 CE cycles between WEs; DONE after pos 30.
- PORT_EN=00 -> F0,F0, then 29×00; exactly 31 WE pulses total.
- PORT_EN=01, JOY1 changed to FFFF after first WE -> data bytes use latched value (0000 gives FF,FC); port-2 byte is F0 at pos 4.
- INPUT_ACT drops while in GAP after 3 writes -> no further WE; BUSY=0 next CE cycle; new rise restarts from FIRST_DELAY.
- CE toggled 1-in-3 -> WE width equals one CE-active cycle; gap counted in CE cycles only; byte sequence identical to the 2nd scenario.

Source files
------------

// File: rtl/smpc_pad_scanner.sv
// Peripheral byte sequencer for the SMPC INTBACK peripheral phase: snapshots two
// digital-pad ports on request and emits one OREG byte per paced INPUT_WE strobe.
module smpc_pad_scanner #(
    parameter logic [15:0] FIRST_DELAY = 16'd400,
    parameter logic [15:0] BYTE_GAP    = 16'd20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic [1:0]  PORT_EN,
    input  logic [15:0] JOY1,
    input  logic [15:0] JOY2,
    input  logic        INPUT_ACT,
    input  logic [4:0]  INPUT_POS,
    output logic [7:0]  INPUT_DATA,
    output logic        INPUT_WE,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_POS = 5'd30;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  conn, conn_n;
    logic [15:3] snap1, snap1_n;
    logic [15:3] snap2, snap2_n;
    logic        act_d;
    logic [7:0]  data_n;
    logic        we_n;

    // The three low button bits carry nothing on a digital pad.
    logic unused_joy_bits;
    assign unused_joy_bits = ^{JOY1[2:0], JOY2[2:0]};

    function automatic logic [7:0] port_byte(input logic        connected,
                                             input logic [15:3] s,
                                             input logic [4:0]  off);
        logic [7:0] b;
        b = 8'h00;
        if (!connected) begin
            b = 8'hF0;
        end else begin
            case (off)
                5'd0:    b = 8'hF1;
                5'd1:    b = 8'h02;
                5'd2:    b = ~s[15:8];
                5'd3:    b = {~s[7:3], 3'b100};
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    function automatic logic [7:0] byte_at(input logic [4:0]  pos,
                                           input logic [1:0]  c,
                                           input logic [15:3] s1,
                                           input logic [15:3] s2);
        logic [4:0] len1, len2;
        logic [7:0] b;
        len1 = c[0] ? 5'd4 : 5'd1;
        len2 = c[1] ? 5'd4 : 5'd1;
        if (pos < len1)
            b = port_byte(c[0], s1, pos);
        else if (pos < len1 + len2)
            b = port_byte(c[1], s2, pos - len1);
        else
            b = 8'h00;
        return b;
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        conn_n  = conn;
        snap1_n = snap1;
        snap2_n = snap2;
        data_n  = INPUT_DATA;
        we_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (INPUT_ACT && !act_d) begin
                    conn_n  = PORT_EN;
                    snap1_n = JOY1[15:3];
                    snap2_n = JOY2[15:3];
                    cnt_n   = FIRST_DELAY;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (!INPUT_ACT) begin
                    state_n = S_IDLE;
                end else if (cnt != 16'd0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    // Strobe and byte are registered together on entry to WRITE.
                    we_n    = 1'b1;
                    data_n  = byte_at(INPUT_POS, conn, snap1, snap2);
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!INPUT_ACT) begin
                    state_n = S_IDLE;
                end else if (INPUT_POS == LAST_POS) begin
                    state_n = S_DONE;
                end else begin
                    cnt_n   = BYTE_GAP;
                    state_n = S_GAP;
                end
            end
            S_DONE: begin
                if (!INPUT_ACT)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cnt        <= 16'd0;
            conn       <= 2'b00;
            snap1      <= '0;
            snap2      <= '0;
            act_d      <= 1'b0;
            INPUT_DATA <= 8'h00;
            INPUT_WE   <= 1'b0;
        end else if (CE) begin
            state      <= state_n;
            cnt        <= cnt_n;
            conn       <= conn_n;
            snap1      <= snap1_n;
            snap2      <= snap2_n;
            act_d      <= INPUT_ACT;
            INPUT_DATA <= data_n;
            INPUT_WE   <= we_n;
        end
    end

    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_smpc_pad_scanner.sv
// Directed bench for smpc_pad_scanner: a small SMPC model advances INPUT_POS on
// every consumed strobe while scenario tasks check bytes, pacing and control.
`timescale 1ns/1ps
module tb_smpc_pad_scanner;

    localparam int FD = 400;
    localparam int BG = 20;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE = 1'b1;
    logic [1:0]  PORT_EN = 2'b00;
    logic [15:0] JOY1 = 16'h0000;
    logic [15:0] JOY2 = 16'h0000;
    logic        INPUT_ACT = 1'b0;
    logic [4:0]  INPUT_POS = 5'd0;
    logic [7:0]  INPUT_DATA;
    logic        INPUT_WE;
    logic        BUSY;

    smpc_pad_scanner #(.FIRST_DELAY(16'd400), .BYTE_GAP(16'd20)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .PORT_EN(PORT_EN),
        .JOY1(JOY1), .JOY2(JOY2), .INPUT_ACT(INPUT_ACT), .INPUT_POS(INPUT_POS),
        .INPUT_DATA(INPUT_DATA), .INPUT_WE(INPUT_WE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // CE generator: high one clock in every ce_div clocks, changed at negedge.
    int ce_div = 1;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge CLK);
            ph = (ph + 1) % ce_div;
            CE = (ph == 0);
        end
    end

    // SMPC model: a strobe is consumed on a CE edge, after which POS advances.
    int       ce_idx = 0;
    int       rise_idx = 0;
    int       n_take = 0;
    int       wide = 0;
    int       last_take = -10;
    logic [7:0] byte_log [0:63];
    int       take_log [0:63];
    initial begin
        bit         take, act_seen;
        logic [7:0] d;
        act_seen = 1'b0;
        forever begin
            @(posedge CLK);
            take = 1'b0;
            d = 8'h00;
            if (!RST_N) act_seen = 1'b0;
            else if (CE) begin
                ce_idx++;
                if (INPUT_WE === 1'b1) begin
                    take = 1'b1;
                    d = INPUT_DATA;
                end
                if (INPUT_ACT && !act_seen) rise_idx = ce_idx;
                act_seen = INPUT_ACT;
            end
            #1;
            if (take) begin
                if (last_take == ce_idx - 1 || INPUT_WE !== 1'b0) wide++;
                last_take = ce_idx;
                if (n_take < 64) begin
                    byte_log[n_take] = d;
                    take_log[n_take] = ce_idx;
                end
                n_take++;
                INPUT_POS = INPUT_POS + 5'd1;
            end
        end
    end

    logic [7:0] exp_bytes [0:30];

    task automatic clear_expected();
        for (int i = 0; i < 31; i++) exp_bytes[i] = 8'h00;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (INPUT_WE !== 1'b0 || INPUT_DATA !== 8'h00 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset: we=%b data=%h busy=%b, required we=0 data=00 busy=0",
                     INPUT_WE, INPUT_DATA, BUSY);
        end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Runs a whole session to pos 30 and checks bytes, pacing and DONE handling.
    task automatic run_full_session(input string name, input bit change_joy1);
        int cyc, bad_gap;
        @(negedge CLK);
        INPUT_POS = 5'd0;
        n_take = 0;
        wide = 0;
        INPUT_ACT = 1'b1;
        cyc = 0;
        while (n_take < 31 && cyc < 15000) begin
            @(negedge CLK);
            cyc++;
            if (change_joy1 && n_take >= 1) JOY1 = 16'hFFFF;
        end
        checks++;
        if (n_take < 31) begin
            errors++;
            $display("FAIL %s timeout: strobes=%0d, required 31", name, n_take);
        end else begin
            // Strobe rises FD+1 CE cycles after the rise; consumed one later.
            checks++;
            if (take_log[0] - rise_idx - 1 != FD + 1) begin
                errors++;
                $display("FAIL %s first_delay: %0d CE cycles, required %0d",
                         name, take_log[0] - rise_idx - 1, FD + 1);
            end
            // One CE cycle high plus BG+1 low between consecutive strobes.
            bad_gap = 0;
            for (int i = 1; i < 31; i++)
                if (take_log[i] - take_log[i-1] != BG + 2) bad_gap++;
            checks++;
            if (bad_gap != 0) begin
                errors++;
                $display("FAIL %s byte_gap: %0d wrong spacings (first spacing %0d), required 0 (spacing %0d)",
                         name, bad_gap, take_log[1] - take_log[0], BG + 2);
            end
            for (int i = 0; i < 31; i++) begin
                checks++;
                if (byte_log[i] !== exp_bytes[i]) begin
                    errors++;
                    $display("FAIL %s byte[%0d]: got %h, required %h",
                             name, i, byte_log[i], exp_bytes[i]);
                end
            end
        end
        checks++;
        if (wide != 0) begin
            errors++;
            $display("FAIL %s we_width: %0d long pulses, required 0", name, wide);
        end
        repeat (60) @(negedge CLK);
        checks++;
        if (n_take != 31 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s done_hold: strobes=%0d busy=%b, required 31 and 1",
                     name, n_take, BUSY);
        end
        INPUT_ACT = 1'b0;
        repeat (2 * ce_div + 1) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s done_exit: busy=%b, required 0", name, BUSY);
        end
    endtask

    task automatic test_two_pads();
        PORT_EN = 2'b11;
        JOY1 = 16'h8000;
        JOY2 = 16'h0008;
        clear_expected();
        exp_bytes[0] = 8'hF1; exp_bytes[1] = 8'h02; exp_bytes[2] = 8'h7F; exp_bytes[3] = 8'hFC;
        exp_bytes[4] = 8'hF1; exp_bytes[5] = 8'h02; exp_bytes[6] = 8'hFF; exp_bytes[7] = 8'hF4;
        run_full_session("two_pads", 1'b0);
    endtask

    task automatic test_no_pads(input string name);
        PORT_EN = 2'b00;
        JOY1 = 16'hA5A5;
        JOY2 = 16'h5A5A;
        clear_expected();
        exp_bytes[0] = 8'hF0; exp_bytes[1] = 8'hF0;
        run_full_session(name, 1'b0);
    endtask

    task automatic test_snapshot();
        PORT_EN = 2'b01;
        JOY1 = 16'h0000;
        JOY2 = 16'h1234;
        clear_expected();
        exp_bytes[0] = 8'hF1; exp_bytes[1] = 8'h02; exp_bytes[2] = 8'hFF; exp_bytes[3] = 8'hFC;
        exp_bytes[4] = 8'hF0;
        run_full_session("snapshot", 1'b1);
    endtask

    task automatic test_abort();
        int cyc;
        PORT_EN = 2'b11;
        JOY1 = 16'h0000;
        JOY2 = 16'h0000;
        @(negedge CLK);
        INPUT_POS = 5'd0;
        n_take = 0;
        INPUT_ACT = 1'b1;
        cyc = 0;
        while (n_take < 3 && cyc < 3000) begin @(negedge CLK); cyc++; end
        repeat (5) @(negedge CLK);
        INPUT_ACT = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0 || INPUT_WE !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b we=%b, required 0 0", BUSY, INPUT_WE);
        end
        repeat (60) @(negedge CLK);
        checks++;
        if (n_take != 3) begin
            errors++;
            $display("FAIL abort_writes: strobes=%0d, required 3", n_take);
        end
        // Re-arm: the new session starts over from the full first delay.
        INPUT_POS = 5'd0;
        n_take = 0;
        INPUT_ACT = 1'b1;
        cyc = 0;
        while (n_take < 1 && cyc < 3000) begin @(negedge CLK); cyc++; end
        checks++;
        if (n_take < 1 || take_log[0] - rise_idx - 1 != FD + 1 || byte_log[0] !== 8'hF1) begin
            errors++;
            $display("FAIL rearm: strobes=%0d delay=%0d byte=%h, required >=1 %0d F1",
                     n_take, take_log[0] - rise_idx - 1, byte_log[0], FD + 1);
        end
    endtask

    // Reset during a live session, with a nonzero byte on INPUT_DATA.
    task automatic test_mid_reset();
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (BUSY !== 1'b0 || INPUT_WE !== 1'b0 || INPUT_DATA !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: busy=%b we=%b data=%h, required 0 0 00",
                     BUSY, INPUT_WE, INPUT_DATA);
        end
        @(negedge CLK);
        INPUT_ACT = 1'b0;
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_two_pads();
        test_no_pads("no_pads");
        test_snapshot();
        test_abort();
        test_mid_reset();
        ce_div = 3;
        test_no_pads("ce_third");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
